// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the vehicle light FSM and the pedestrian
// crossing controller.
//   ped_state_t    - pedestrian controller state encoding
//   LIGHT_*        - one-hot [Red, Yellow, Green] vehicle light codes
//   lights_legal() - true when a light vector is one of the three legal codes
package traffic_pkg;

    typedef enum logic [1:0] {
        PED_STOP  = 2'd0,
        PED_WALK  = 2'd1,
        PED_FLASH = 2'd2
    } ped_state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Anything other than exactly one lamp lit (including all dark) is illegal.
    function automatic logic lights_legal(input logic [2:0] l);
        return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-bit rising-edge detector.
//   clk  - clock
//   rst  - synchronous active-high reset (previous value clears to 0)
//   d    - input level, synchronous to clk
//   rise - high while d=1 and the previously sampled d was 0
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q_reg <= 1'b0;
        end else begin
            d_q_reg <= d;
        end
    end

    assign rise = d & ~d_q_reg;

endmodule

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian crossing controller downstream of the vehicle
// light FSM. Grants a timed WALK followed by a flashing clearance when the
// vehicle lights turn red with a request pending; forces DON'T WALK at once if
// the lights leave red early or show an illegal code.
//   WALK_CYC    - cycles WALK is held (1..15)
//   CLEAR_CYC   - cycles of flashing clearance (1..15)
//   clk, rst    - clock, synchronous active-high reset
//   lights      - vehicle lights [Red, Yellow, Green]
//   ped_button  - crosswalk button level
//   walk        - WALK lamp
//   dont_walk   - DON'T WALK lamp (solid, or flashing during clearance)
//   req_pending - a request is latched and not yet served
//   countdown   - remaining clearance cycles, 0 outside clearance
//   abort       - one-cycle pulse: lights left red during WALK/clearance
//   fault       - one-cycle pulse: illegal lights code sampled
module ped_signal_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned WALK_CYC  = 5,
    parameter int unsigned CLEAR_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] lights,
    input  logic       ped_button,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [3:0] countdown,
    output logic       abort,
    output logic       fault
);

    localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYC - 1);
    localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_CYC);

    ped_state_t state_reg, state_next;
    logic [3:0] timer_reg, timer_next;
    logic [3:0] countdown_reg, countdown_next;
    logic [2:0] lights_q_reg;
    logic       walk_reg, walk_next;
    logic       dont_walk_reg, dont_walk_next;
    logic       req_pending_reg, req_pending_next;
    logic       abort_reg, abort_next;
    logic       fault_reg, fault_next;

    logic button_rise;
    logic red_edge;
    logic legal;

    rise_detect u_button_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (ped_button),
        .rise (button_rise)
    );

    // lights_q resets to red so the upstream FSM coming out of reset in red
    // is not mistaken for a fresh red phase.
    assign red_edge = (lights == LIGHT_RED) && (lights_q_reg != LIGHT_RED);
    assign legal    = lights_legal(lights);

    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        countdown_next   = 4'd0;
        walk_next        = 1'b0;
        dont_walk_next   = 1'b1;
        req_pending_next = req_pending_reg;
        abort_next       = 1'b0;
        fault_next       = 1'b0;

        if (!legal) begin
            // Illegal code wins over everything; the pending request survives.
            state_next = PED_STOP;
            fault_next = 1'b1;
        end else begin
            // A press during WALK belongs to the request already being served.
            if (button_rise && (state_reg != PED_WALK)) begin
                req_pending_next = 1'b1;
            end

            if ((state_reg != PED_STOP) && (lights != LIGHT_RED)) begin
                state_next = PED_STOP;
                abort_next = 1'b1;
            end else begin
                case (state_reg)
                    PED_STOP: begin
                        // Uses the registered request, so a press arriving on
                        // the red edge itself waits for the next red phase.
                        if (red_edge && req_pending_reg) begin
                            state_next       = PED_WALK;
                            walk_next        = 1'b1;
                            dont_walk_next   = 1'b0;
                            timer_next       = WALK_LOAD;
                            req_pending_next = 1'b0;
                        end
                    end
                    PED_WALK: begin
                        if (timer_reg == 4'd0) begin
                            state_next     = PED_FLASH;
                            countdown_next = CLEAR_LOAD;
                        end else begin
                            timer_next     = timer_reg - 4'd1;
                            walk_next      = 1'b1;
                            dont_walk_next = 1'b0;
                        end
                    end
                    PED_FLASH: begin
                        if (countdown_reg == 4'd1) begin
                            state_next = PED_STOP;
                        end else begin
                            countdown_next = countdown_reg - 4'd1;
                            dont_walk_next = ~dont_walk_reg;
                        end
                    end
                    default: begin
                        state_next = PED_STOP;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= PED_STOP;
            timer_reg       <= 4'd0;
            countdown_reg   <= 4'd0;
            lights_q_reg    <= LIGHT_RED;
            walk_reg        <= 1'b0;
            dont_walk_reg   <= 1'b1;
            req_pending_reg <= 1'b0;
            abort_reg       <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            countdown_reg   <= countdown_next;
            lights_q_reg    <= lights;
            walk_reg        <= walk_next;
            dont_walk_reg   <= dont_walk_next;
            req_pending_reg <= req_pending_next;
            abort_reg       <= abort_next;
            fault_reg       <= fault_next;
        end
    end

    assign walk        = walk_reg;
    assign dont_walk   = dont_walk_reg;
    assign req_pending = req_pending_reg;
    assign countdown   = countdown_reg;
    assign abort       = abort_reg;
    assign fault       = fault_reg;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
module tb_ped_signal_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] lights;
    logic       ped_button;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [3:0] countdown;
    logic       abort;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    ped_signal_ctrl #(.WALK_CYC(5), .CLEAR_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .lights      (lights),
        .ped_button  (ped_button),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .countdown   (countdown),
        .abort       (abort),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; lights = 3'b100; ped_button = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Press and release in green, step through yellow into red.
    // Returns after the edge that entered WALK (walk cycle 1 visible).
    task automatic request_and_red();
        lights = 3'b001; ped_button = 1'b1; tick();
        ped_button = 1'b0; tick();
        lights = 3'b010; tick();
        lights = 3'b100; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; lights = 3'b100; ped_button = 1'b0;
        tick(); tick();
        checks++;
        if ({walk, dont_walk, req_pending, countdown, abort, fault} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got walk=%b dw=%b req=%b cd=%0d abort=%b fault=%b required 0 1 0 0 0 0",
                     walk, dont_walk, req_pending, countdown, abort, fault);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (walk !== 1'b0 || dont_walk !== 1'b1) begin
                failures++;
                $display("FAIL reset_release_cycle%0d: got walk=%b dw=%b required walk=0 dw=1", i, walk, dont_walk);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_normal_cycle();
        logic [3:0] exp_cd [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        logic       exp_dw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        lights = 3'b001; ped_button = 1'b1; tick();
        checks++;
        if (req_pending !== 1'b1) begin
            failures++;
            $display("FAIL normal_req_latch: got req_pending=%b required 1", req_pending);
        end
        ped_button = 1'b0; tick();
        lights = 3'b010; tick();
        checks++;
        if (walk !== 1'b0 || req_pending !== 1'b1) begin
            failures++;
            $display("FAIL normal_yellow: got walk=%b req=%b required walk=0 req=1", walk, req_pending);
        end
        lights = 3'b100;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (walk !== 1'b1 || dont_walk !== 1'b0 || req_pending !== 1'b0 || countdown !== 4'd0) begin
                failures++;
                $display("FAIL normal_walk_cycle%0d: got walk=%b dw=%b req=%b cd=%0d required 1 0 0 0",
                         i + 1, walk, dont_walk, req_pending, countdown);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (walk !== 1'b0 || countdown !== exp_cd[i] || dont_walk !== exp_dw[i]) begin
                failures++;
                $display("FAIL normal_flash_cycle%0d: got walk=%b cd=%0d dw=%b required walk=0 cd=%0d dw=%b",
                         i + 1, walk, countdown, dont_walk, exp_cd[i], exp_dw[i]);
            end
        end
        tick();
        checks++;
        if (walk !== 1'b0 || dont_walk !== 1'b1 || countdown !== 4'd0 || abort !== 1'b0) begin
            failures++;
            $display("FAIL normal_back_to_stop: got walk=%b dw=%b cd=%0d abort=%b required 0 1 0 0",
                     walk, dont_walk, countdown, abort);
        end
        $display("test_normal_cycle done");
    endtask

    task automatic test_no_request();
        do_reset();
        lights = 3'b001; tick();
        lights = 3'b010; tick();
        lights = 3'b100;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (walk !== 1'b0 || dont_walk !== 1'b1 || req_pending !== 1'b0) begin
                failures++;
                $display("FAIL no_request_cycle%0d: got walk=%b dw=%b req=%b required 0 1 0",
                         i, walk, dont_walk, req_pending);
            end
        end
        $display("test_no_request done");
    endtask

    task automatic test_abort();
        do_reset();
        request_and_red();
        tick(); tick();                 // now in WALK cycle 3
        lights = 3'b001; tick();
        checks++;
        if (walk !== 1'b0 || dont_walk !== 1'b1 || abort !== 1'b1 || countdown !== 4'd0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL abort_response: got walk=%b dw=%b abort=%b cd=%0d fault=%b required 0 1 1 0 0",
                     walk, dont_walk, abort, countdown, fault);
        end
        tick();
        checks++;
        if (abort !== 1'b0 || walk !== 1'b0) begin
            failures++;
            $display("FAIL abort_one_cycle: got abort=%b walk=%b required abort=0 walk=0", abort, walk);
        end
        $display("test_abort done");
    endtask

    task automatic test_illegal();
        do_reset();
        lights = 3'b001; ped_button = 1'b1; tick();
        ped_button = 1'b0;
        lights = 3'b110; tick();
        checks++;
        if (fault !== 1'b1 || abort !== 1'b0 || req_pending !== 1'b1 || dont_walk !== 1'b1) begin
            failures++;
            $display("FAIL illegal_fault: got fault=%b abort=%b req=%b dw=%b required 1 0 1 1",
                     fault, abort, req_pending, dont_walk);
        end
        lights = 3'b001; tick();
        checks++;
        if (fault !== 1'b0 || req_pending !== 1'b1) begin
            failures++;
            $display("FAIL illegal_fault_pulse: got fault=%b req=%b required fault=0 req=1", fault, req_pending);
        end
        lights = 3'b100; tick();
        checks++;
        if (walk !== 1'b1 || req_pending !== 1'b0) begin
            failures++;
            $display("FAIL illegal_then_served: got walk=%b req=%b required walk=1 req=0", walk, req_pending);
        end
        $display("test_illegal done");
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        request_and_red();
        tick();                         // WALK cycle 2
        rst = 1'b1; tick();
        checks++;
        if ({walk, dont_walk, req_pending, countdown, abort, fault} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_walk: got walk=%b dw=%b req=%b cd=%0d abort=%b fault=%b required 0 1 0 0 0 0",
                     walk, dont_walk, req_pending, countdown, abort, fault);
        end
        rst = 1'b0; tick();
        checks++;
        if (walk !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_walk_release: got walk=%b required 0", walk);
        end
        $display("test_reset_mid_walk done");
    endtask

    task automatic test_button_held();
        do_reset();
        // Held from STOP for 20 cycles: latched once, served, never re-latched.
        lights = 3'b001; ped_button = 1'b1; tick();
        checks++;
        if (req_pending !== 1'b1) begin
            failures++;
            $display("FAIL held_latch: got req_pending=%b required 1", req_pending);
        end
        lights = 3'b010; tick();
        lights = 3'b100; tick();
        checks++;
        if (walk !== 1'b1) begin
            failures++;
            $display("FAIL held_walk_entry: got walk=%b required 1", walk);
        end
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (req_pending !== 1'b0 || walk !== 1'b0 || dont_walk !== 1'b1) begin
            failures++;
            $display("FAIL held_once_only: got req=%b walk=%b dw=%b required 0 0 1", req_pending, walk, dont_walk);
        end
        ped_button = 1'b0; tick();

        // Press starting during WALK and held past STOP is dropped.
        do_reset();
        request_and_red();
        tick();
        ped_button = 1'b1; tick();
        checks++;
        if (req_pending !== 1'b0) begin
            failures++;
            $display("FAIL walk_press_ignored: got req_pending=%b required 0", req_pending);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (req_pending !== 1'b0 || dont_walk !== 1'b1 || countdown !== 4'd0) begin
            failures++;
            $display("FAIL walk_press_dropped: got req=%b dw=%b cd=%0d required 0 1 0", req_pending, dont_walk, countdown);
        end
        ped_button = 1'b0; tick();
        $display("test_button_held done");
    endtask

    initial begin
        rst = 1'b1; lights = 3'b100; ped_button = 1'b0;
        test_reset();
        test_normal_cycle();
        test_no_request();
        test_abort();
        test_illegal();
        test_reset_mid_walk();
        test_button_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
